hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor of the pipeline's hazard detection unit. It replaces the fixed EXE/MEM destination compare with an internal shadow pipeline of in-flight destination tags of configurable depth. In forwarding mode it generates registered per-source forward selects for the EXE stage and stalls only on load-use; in stall mode it freezes on any match. It sits beside the ID stage, and its hazard output drives the IF freeze and the ID/EX bubble.

## Interface
- NUM_SRC, 2: number of source operands checked per instruction (1..3).
- REG_W, 4: register address width.
- DEPTH, 2: tracked stages after ID before register-file write (slot 0 = EXE, slot DEPTH-1 = last checked stage).
- FWD_EN, 1: 0 = stall on any match; 1 = forward, stall only on load-use.
- SEL_W, $clog2(DEPTH+1): forward select width per source.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- src  in  NUM_SRC*REG_W  source register numbers; source i is at [i*REG_W +: REG_W].
- src_valid  in  NUM_SRC  per-source valid (Rn-valid, two-source).
- dest  in  REG_W  destination of the ID instruction.
- wb_en  in  1  ID instruction writes the register file.
- mem_r_en  in  1  ID instruction is a load.
- flush  in  1  branch taken in EXE; kills the ID instruction.
- hazard  out  1  combinational stall request.
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered forward select per source, aligned with the instruction now in EXE. 0 = register-file value; k = result of the stage k positions past EXE (1 = EX/MEM register, 2 = MEM/WB register, …).
- stall_count  out  32  saturating count of hazard cycles.

## Operation
- Each slot holds {valid, dest, is_load}. Slots shift every cycle: slot k moves to slot k+1, and slot DEPTH-1 is discarded.
- Insert into slot 0: {id_valid & wb_en & ~hazard & ~flush, dest, mem_r_en}. Otherwise slot 0 receives a bubble (valid=0).
- Match(i,k) = src_valid[i] & slot[k].valid & (slot[k].dest == src[i]).
- FWD_EN=0: hazard = id_valid & any Match(i,k). ex_fwd_sel is held at 0.
- FWD_EN=1:
  - hazard = id_valid & any Match(i,0) with slot[0].is_load (load-use).
  - For each source, the youngest matching slot (lowest k) sets the next select to k+1. With no match the select is 0.
  - Matches in older slots are masked by a younger match on the same register.
- ex_fwd_sel register loads the next selects when the instruction enters EXE. It loads all zeros when hazard, flush or ~id_valid is asserted.
- stall_count increments on each hazard cycle and saturates at 0xFFFFFFFF.
- Entries leaving slot DEPTH-1 are never checked. The register file is write-before-read.

## Timing
- Reset: all slot valids 0, ex_fwd_sel 0, stall_count 0. hazard follows its inputs, so it is 0 after reset with empty slots. Reset mid-operation drops all in-flight tags immediately.
- hazard: zero-latency combinational path from src, src_valid, id_valid and slot state.
- ex_fwd_sel: one-cycle latency. The value selected while an instruction is in ID is presented on the cycle it is in EXE.
- Load-use stall lasts exactly 1 cycle. The load then sits in slot 1 and the consumer gets select 2.
- FWD_EN=0: stall persists until the producer has left slot DEPTH-1. The stall is at most DEPTH cycles.
- flush and hazard together: one bubble is inserted, the flush takes priority, and stall_count still increments.
- flush with id_valid=0 inserts a bubble only.

## Test plan
- FWD_EN=1, DEPTH=2. Issue ADD r1 then SUB r2,r1,r3 back-to-back. Required: hazard stays 0, and ex_fwd_sel for src0 = 1 in SUB's EXE cycle.
- FWD_EN=1. Issue LDR r4, then ADD r5,r4,r4. Required: hazard=1 for exactly 1 cycle and stall_count=1. ADD then enters EXE with both selects = 2.
- FWD_EN=1. Issue MOV r1 (slot 1) and ADD r1 (slot 0) ahead of a consumer of r1. Required: select = 1, the youngest producer wins.
- FWD_EN=0, DEPTH=2. Issue ADD r7 then a consumer of r7. Required: hazard=1 for 2 cycles, then release with ex_fwd_sel=0.
- Branch in EXE (flush=1) while ID holds ADD r9 with wb_en=1. Then issue a consumer of r9. Required: no match and hazard=0, because r9 was never inserted.
- Assert rst with slots holding r2 and r3. Required: after release, consumers of r2 and r3 see hazard=0, select 0 and stall_count=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard detection for the ID stage. A short shadow pipeline of in-flight
// destination tags (slot 0 = EXE ... slot DEPTH-1 = last checked stage) is
// compared against the source operands of the instruction now in ID.
//   FWD_EN = 0 : stall while any in-flight producer matches a source.
//   FWD_EN = 1 : stall only on load-use (load in slot 0). Otherwise a
//                registered forward select per source is handed to EXE.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   id_valid      ID holds a real instruction
//   src           NUM_SRC packed source register numbers (REG_W each)
//   src_valid     per-source valid
//   dest          destination register of the ID instruction
//   wb_en         ID instruction writes the register file
//   mem_r_en      ID instruction is a load
//   flush         branch taken in EXE; kills the ID instruction
//   hazard        combinational stall request (IF freeze / ID-EX bubble)
//   ex_fwd_sel    registered forward select per source for the EXE stage:
//                 0 = register file, k = stage k positions past EXE
//   stall_count   saturating count of hazard cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 2,
    parameter int FWD_EN  = 1,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   src,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [REG_W-1:0]           dest,
    input  logic                       wb_en,
    input  logic                       mem_r_en,
    input  logic                       flush,
    output logic                       hazard,
    output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
    output logic [31:0]                stall_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } slot_t;

    slot_t                     slot_q [DEPTH];
    slot_t                     slot_d [DEPTH];
    logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_q, ex_fwd_sel_d;
    logic [NUM_SRC*SEL_W-1:0]  sel_next;
    logic [31:0]               stall_count_q, stall_count_d;

    logic any_match;
    logic load_use;
    logic found;

    // ------------------------------------------------------------------------
    // Tag compare, hazard and next forward selects
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_match = 1'b0;
        load_use  = 1'b0;
        found     = 1'b0;
        sel_next  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            // Walk from youngest (slot 0) to oldest; the first hit wins, so an
            // older producer of the same register is masked.
            for (int k = 0; k < DEPTH; k++) begin
                if (src_valid[i] && slot_q[k].valid &&
                    (slot_q[k].dest == src[i*REG_W +: REG_W])) begin
                    any_match = 1'b1;
                    if (k == 0 && slot_q[0].is_load) begin
                        load_use = 1'b1;
                    end
                    if (!found) begin
                        sel_next[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        found                      = 1'b1;
                    end
                end
            end
        end

        if (FWD_EN != 0) begin
            hazard = id_valid & load_use;
        end else begin
            hazard = id_valid & any_match;
        end

        // Slot 0 takes the ID instruction only when it really advances into
        // EXE and writes back; a stall or flush injects a bubble instead.
        slot_d[0].valid   = id_valid & wb_en & ~hazard & ~flush;
        slot_d[0].dest    = dest;
        slot_d[0].is_load = mem_r_en;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end

        // The select follows the instruction into EXE; a bubble gets zeros.
        if (FWD_EN == 0 || hazard || flush || !id_valid) begin
            ex_fwd_sel_d = '0;
        end else begin
            ex_fwd_sel_d = sel_next;
        end

        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which is what makes the slot shift work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag array is reset (unlike a data memory) because a
            // stale valid bit would raise a false hazard after reset.
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            ex_fwd_sel_q  <= '0;
            stall_count_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            ex_fwd_sel_q  <= ex_fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_fwd_sel  = ex_fwd_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Two scoreboards (forwarding and stall mode, DEPTH=2) share one ID stream.
// Each table row is one ID cycle: inputs plus the hand-computed hazard,
// EXE forward select and stall count expected from each instance in that
// cycle. Outputs are sampled 1 ns after the falling edge where inputs change.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int REG_W   = 4;
    localparam int DEPTH   = 2;
    localparam int SEL_W   = 2;

    logic                      clk;
    logic                      rst;
    logic                      id_valid;
    logic [NUM_SRC*REG_W-1:0]  src;
    logic [NUM_SRC-1:0]        src_valid;
    logic [REG_W-1:0]          dest;
    logic                      wb_en;
    logic                      mem_r_en;
    logic                      flush;

    logic                      haz_f, haz_s;
    logic [NUM_SRC*SEL_W-1:0]  sel_f, sel_s;
    logic [31:0]               cnt_f, cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .DEPTH(DEPTH), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src(src), .src_valid(src_valid),
        .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en), .flush(flush),
        .hazard(haz_f), .ex_fwd_sel(sel_f), .stall_count(cnt_f)
    );

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .DEPTH(DEPTH), .FWD_EN(0)) u_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src(src), .src_valid(src_valid),
        .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en), .flush(flush),
        .hazard(haz_s), .ex_fwd_sel(sel_s), .stall_count(cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         do_rst;
        logic       idv;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] sv;
        logic [3:0] dst;
        logic       wb;
        logic       ld;
        logic       fl;
        logic       exp_haz_f;
        logic [3:0] exp_sel_f;
        int         exp_cnt_f;
        logic       exp_haz_s;
        int         exp_cnt_s;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic idv, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] sv, input logic [3:0] dst, input logic wb,
                       input logic ld, input logic fl, input logic hf, input logic [3:0] sf,
                       input int cf, input logic hs, input int cs);
        vec_t v;
        v.do_rst = r;   v.idv = idv; v.s0 = s0; v.s1 = s1; v.sv = sv; v.dst = dst;
        v.wb = wb;      v.ld = ld;   v.fl = fl;
        v.exp_haz_f = hf; v.exp_sel_f = sf; v.exp_cnt_f = cf;
        v.exp_haz_s = hs; v.exp_cnt_s = cs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic idv, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] sv, input logic [3:0] dst, input logic wb,
                         input logic ld, input logic fl);
        id_valid  = idv;
        src       = {s1, s0};
        src_valid = sv;
        dest      = dst;
        wb_en     = wb;
        mem_r_en  = ld;
        flush     = fl;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  released;

        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);

        //   rst idv s0 s1 sv     dst wb ld fl | hf sel_f    cf | hs cs
        // ADD r1 ; SUB r2,r1,r3 back to back: forwarded with select 1.
        add(1, 1, 0, 0, 2'b00, 1, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 1, 3, 2'b11, 2, 1, 0, 0,   0, 4'b0000, 0,   1, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0001, 0,   0, 1);
        // LDR r4 ; ADD r5,r4,r4 held in ID: one-cycle load-use stall, then select 2.
        add(1, 1, 0, 0, 2'b00, 4, 1, 1, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 4, 4, 2'b11, 5, 1, 0, 0,   1, 4'b0000, 0,   1, 0);
        add(0, 1, 4, 4, 2'b11, 5, 1, 0, 0,   0, 4'b0000, 1,   1, 1);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b1010, 1,   0, 2);
        // MOV r1 ; ADD r1 ; consumer of r1: youngest producer (select 1) wins.
        add(1, 1, 0, 0, 2'b00, 1, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 0, 0, 2'b00, 1, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 1, 1, 2'b11, 6, 0, 0, 0,   0, 4'b0000, 0,   1, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0101, 0,   0, 1);
        // ADD r7 ; consumer (src1=r7) held: stall mode stalls 2 cycles.
        add(1, 1, 0, 0, 2'b00, 7, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 3, 7, 2'b11, 8, 1, 0, 0,   0, 4'b0000, 0,   1, 0);
        add(0, 1, 3, 7, 2'b11, 8, 1, 0, 0,   0, 4'b0100, 0,   1, 1);
        add(0, 1, 3, 7, 2'b11, 8, 1, 0, 0,   0, 4'b1000, 0,   0, 2);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0000, 0,   0, 2);
        // Flushed ADD r9 is never inserted; flush together with load-use still counts.
        add(1, 1, 0, 0, 2'b00, 9, 1, 0, 1,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 9, 9, 2'b11, 0, 0, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 0, 0, 2'b00, 4, 1, 1, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 4, 0, 2'b01, 0, 0, 0, 1,   1, 4'b0000, 0,   1, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0000, 1,   0, 1);
        // r2, r3 in flight, then reset: everything dropped.
        add(1, 1, 0, 0, 2'b00, 2, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 1, 0, 0, 2'b00, 3, 1, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(1, 1, 2, 3, 2'b11, 0, 0, 0, 0,   0, 4'b0000, 0,   0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 4'b0000, 0,   0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            if (vecs[n].do_rst) pulse_reset();
            drive(vecs[n].idv, vecs[n].s0, vecs[n].s1, vecs[n].sv, vecs[n].dst,
                  vecs[n].wb, vecs[n].ld, vecs[n].fl);
            #1;
            check($sformatf("v%0d hazard_fwd", n),   32'(haz_f), 32'(vecs[n].exp_haz_f));
            check($sformatf("v%0d sel_fwd", n),      32'(sel_f), 32'(vecs[n].exp_sel_f));
            check($sformatf("v%0d count_fwd", n),    cnt_f,      32'(vecs[n].exp_cnt_f));
            check($sformatf("v%0d hazard_stall", n), 32'(haz_s), 32'(vecs[n].exp_haz_s));
            check($sformatf("v%0d sel_stall", n),    32'(sel_s), 32'd0);
            check($sformatf("v%0d count_stall", n),  cnt_s,      32'(vecs[n].exp_cnt_s));
        end

        // Stall mode, src0 consumer of r7 held in ID: hazard must drop by
        // itself after exactly DEPTH cycles (bounded wait).
        @(negedge clk);
        pulse_reset();
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc      = 0;
        released = 1'b0;
        for (int c = 0; c < 10 && !released; c++) begin
            #1;
            if (haz_s) cyc++;
            else       released = 1'b1;
            if (!released) @(negedge clk);
        end
        check("stall_released", 32'(released), 32'd1);
        check("stall_length",   32'(cyc),      32'(DEPTH));
        @(negedge clk);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("stall_release_sel",   32'(sel_s), 32'd0);
        check("stall_release_count", cnt_s,      32'(DEPTH));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
